// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative, write-back, write-allocate data cache
// with an integrated miss controller and true-LRU replacement.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cpu_req/we        access request (sampled in IDLE only), 1 = store
//   cpu_u_b_h_w       [1] word, [0] half, else byte; [2] unsigned load
//   cpu_addr/din      byte address, right-aligned store data
//   cpu_ready         one-cycle completion pulse
//   cpu_dout/hit      load data (extended) and first-lookup hit, valid with cpu_ready
//   mem_req/we        word transfer request, 1 = writeback, 0 = refill
//   mem_addr/dout     word address and writeback data of the current transfer
//   mem_din/ack       refill data and per-word acknowledge
//   dbg_state         current controller state
//
// Memory handshake: mem_req stays high for a whole burst; mem_addr, mem_we
// and mem_dout hold until a cycle with mem_ack, and each ack cycle moves
// exactly one word. mem_ack is ignored outside WB/FILL.
module cache_nway_wb #(
  parameter int ADDR_BITS   = 32,
  parameter int WAYS        = 4,
  parameter int SETS        = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [2:0]           cpu_u_b_h_w,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [31:0]          cpu_din,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_dout,
  output logic                 cpu_hit,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_dout,
  input  logic [31:0]          mem_din,
  input  logic                 mem_ack,
  output logic [1:0]           dbg_state
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = ADDR_BITS - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL} state_t;

  state_t                 r_state;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_we;
  logic [31:0]            r_din;
  logic [2:0]             r_ubhw;
  logic                   r_miss;
  logic [WORD_W-1:0]      r_cnt;
  logic [WAY_W-1:0]       r_victim;
  logic                   r_cpu_ready, r_cpu_hit, r_mem_req, r_mem_we;
  logic [31:0]            r_cpu_dout, r_mem_dout;
  logic [ADDR_BITS-1:0]   r_mem_addr;

  logic [WAYS-1:0]        r_valid [SETS];
  logic [WAYS-1:0]        r_dirty [SETS];
  logic [WAY_W-1:0]       r_age   [SETS][WAYS];
  logic [TAG_W-1:0]       r_tag   [SETS][WAYS];
  logic [31:0]            r_data  [SETS][WAYS][BLOCK_WORDS];

  logic [TAG_W-1:0]       w_tag;
  logic [IDX_W-1:0]       w_idx;
  logic [WORD_W-1:0]      w_word, w_cnt_nxt;
  logic                   w_hit, w_last;
  logic [WAY_W-1:0]       w_hit_way, w_victim;
  logic [31:0]            w_hit_word, w_load, w_merged;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;

  assign w_tag     = r_addr[ADDR_BITS-1 -: TAG_W];
  assign w_idx     = r_addr[OFF_W +: IDX_W];
  assign w_word    = r_addr[2 +: WORD_W];
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_last    = &r_cnt;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Oldest way by default; any invalid way overrides, scanning downward so
  // the lowest-index invalid way is the one that sticks.
  always_comb begin
    w_victim = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
  end

  assign w_hit_word = r_data[w_idx][w_hit_way][w_word];
  assign w_byte     = w_hit_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half     = w_hit_word[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    if (r_ubhw[1])      w_load = w_hit_word;
    else if (r_ubhw[0]) w_load = {{16{~r_ubhw[2] & w_half[15]}}, w_half};
    else                w_load = {{24{~r_ubhw[2] & w_byte[7]}}, w_byte};
  end

  always_comb begin
    w_merged = w_hit_word;
    if (r_ubhw[1])      w_merged = r_din;
    else if (r_ubhw[0]) w_merged[{r_addr[1], 4'b0000} +: 16] = r_din[15:0];
    else                w_merged[{r_addr[1:0], 3'b000} +: 8] = r_din[7:0];
  end

  // Tag and data storage carry no reset; valid bits make them meaningful.
  always_ff @(posedge clk) begin
    if (r_state == S_LOOKUP && w_hit && r_we)
      r_data[w_idx][w_hit_way][w_word] <= w_merged;
    if (r_state == S_FILL && mem_ack) begin
      r_data[w_idx][r_victim][r_cnt] <= mem_din;
      if (w_last) r_tag[w_idx][r_victim] <= w_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_din       <= '0;
      r_ubhw      <= '0;
      r_miss      <= 1'b0;
      r_cnt       <= '0;
      r_victim    <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_hit   <= 1'b0;
      r_cpu_dout  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_dout  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
      end
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_din   <= cpu_din;
            r_ubhw  <= cpu_u_b_h_w;
            r_miss  <= 1'b0;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_cpu_dout  <= w_load;
            r_cpu_hit   <= ~r_miss;
            r_cpu_ready <= 1'b1;
            if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
            // Ages younger than the hit way grow older; the hit way becomes youngest.
            for (int w = 0; w < WAYS; w++)
              if (r_age[w_idx][w] < r_age[w_idx][w_hit_way])
                r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
            r_age[w_idx][w_hit_way] <= '0;
            r_state <= S_IDLE;
          end else begin
            r_miss    <= 1'b1;
            r_victim  <= w_victim;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= {r_tag[w_idx][w_victim], w_idx, {WORD_W{1'b0}}, 2'b00};
              r_mem_dout <= r_data[w_idx][w_victim][0];
              r_state    <= S_WB;
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, {WORD_W{1'b0}}, 2'b00};
              r_state    <= S_FILL;
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            if (w_last) begin
              r_cnt                   <= '0;
              r_dirty[w_idx][r_victim] <= 1'b0;
              r_mem_we                <= 1'b0;
              r_mem_addr              <= {w_tag, w_idx, {WORD_W{1'b0}}, 2'b00};
              r_state                 <= S_FILL;
            end else begin
              r_cnt      <= w_cnt_nxt;
              r_mem_addr <= {r_tag[w_idx][r_victim], w_idx, w_cnt_nxt, 2'b00};
              r_mem_dout <= r_data[w_idx][r_victim][w_cnt_nxt];
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            if (w_last) begin
              r_cnt                    <= '0;
              r_valid[w_idx][r_victim] <= 1'b1;
              r_dirty[w_idx][r_victim] <= 1'b0;
              r_mem_req                <= 1'b0;
              r_state                  <= S_LOOKUP;
            end else begin
              r_cnt      <= w_cnt_nxt;
              r_mem_addr <= {w_tag, w_idx, w_cnt_nxt, 2'b00};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready = r_cpu_ready;
  assign cpu_dout  = r_cpu_dout;
  assign cpu_hit   = r_cpu_hit;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_dout  = r_mem_dout;
  assign dbg_state = r_state;
endmodule
